// File: rtl/vga_fetch.sv
// vga_fetch: single-outstanding framebuffer read master that fills a small FIFO
// drained one word per pix_req by the pixel timing logic.
module vga_fetch #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_4000,
  parameter int FRAME_WORDS = 19200,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 frame_start,
  output logic [31:0]          bus_address,
  output logic                 bus_read,
  input  logic                 bus_wait,
  input  logic [31:0]          bus_readdata,
  input  logic                 pix_req,
  output logic [31:0]          pix_data,
  output logic                 pix_valid,
  output logic                 underflow,
  output logic [FIFO_AW:0]     fifo_level,
  output logic                 frame_done
);
  localparam int CW = $clog2(FRAME_WORDS + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_WORDS - 1);
  localparam logic [FIFO_AW:0] DEPTH = FIFO_DEPTH[FIFO_AW:0];
  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] word_cnt;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [31:0] mem [FIFO_DEPTH];
  logic push, pop, nonempty;
  // bus_read is decoded from state so an async reset drops it immediately
  assign bus_read = state == REQ;
  assign nonempty = fifo_level != '0;
  assign push = bus_read && !bus_wait && !frame_start;
  assign pop = pix_req && nonempty && !frame_start;
  always_comb begin
    state_nx = IDLE;
    if (state == REQ) state_nx = (frame_start || !bus_wait) ? GAP : REQ;
    else if (state == IDLE) state_nx = (!frame_start && enable && !frame_done && fifo_level < DEPTH) ? REQ : IDLE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= bus_readdata;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      pix_data <= '0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= pop;
      if (pop) pix_data <= mem[rd_ptr];
    end
  // frame_start flushes everything and discards a read completing in the same cycle
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      bus_address <= BASE_ADDR;
      word_cnt <= '0;
      frame_done <= 1'b0;
      underflow <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
    end else if (frame_start) begin
      bus_address <= BASE_ADDR;
      word_cnt <= '0;
      frame_done <= 1'b0;
      underflow <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        bus_address <= bus_address + 32'd4;
        word_cnt <= word_cnt + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
        if (word_cnt == LAST) frame_done <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (pix_req && !nonempty) underflow <= 1'b1;
      fifo_level <= fifo_level + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    end
endmodule

// File: tb/tb_vga_fetch.sv
// tb_vga_fetch: bus responder plus scoreboard of captured read data checked against popped pixels.
module tb_vga_fetch;
  localparam logic [31:0] BASE = 32'h0000_4000;
  localparam int FW = 20;
  logic clock = 1'b0;
  logic reset, enable, frame_start, pix_req;
  logic bus_wait, bus_read, pix_valid, underflow, frame_done;
  logic [31:0] bus_address, bus_readdata, pix_data;
  logic [4:0] fifo_level;
  logic [7:0] salt = 8'd0;
  int lat_cnt = 0;
  int passed = 0, total = 0, pops = 0, reads_done = 0;
  logic [31:0] exp_addr = BASE, last_addr = 32'h0;
  logic [31:0] q[$];
  bit gap_pending = 0;

  vga_fetch #(.FRAME_WORDS(FW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .frame_start(frame_start),
    .bus_address(bus_address), .bus_read(bus_read), .bus_wait(bus_wait),
    .bus_readdata(bus_readdata), .pix_req(pix_req), .pix_data(pix_data),
    .pix_valid(pix_valid), .underflow(underflow), .fifo_level(fifo_level),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) lat_cnt <= bus_read ? lat_cnt + 1 : 0;
  assign bus_wait = !(bus_read && lat_cnt == 2);
  assign bus_readdata = bus_wait ? 32'hDEAD_BEEF : ({~bus_address[15:0], bus_address[15:0]} ^ {salt, 24'h0});

  task automatic step();
    logic [31:0] e;
    @(negedge clock);
    if (reset) begin
      q.delete();
      gap_pending = 0;
      exp_addr = BASE;
      reads_done = 0;
    end else begin
      if (pix_valid) begin
        pops++;
        total++;
        if (q.size() == 0) $display("FAIL sb_pop: got %h with no word expected", pix_data);
        else begin
          e = q.pop_front();
          if (pix_data !== e) $display("FAIL sb_pop: got %h expected %h", pix_data, e);
          else passed++;
        end
      end
      if (gap_pending) begin
        total++;
        if (bus_read !== 1'b0) $display("FAIL read_gap: got %b expected 0", bus_read);
        else passed++;
      end
      gap_pending = bus_read && (!bus_wait || frame_start);
      if (frame_start) begin
        q.delete();
        exp_addr = BASE;
        reads_done = 0;
      end else if (bus_read && !bus_wait) begin
        total++;
        if (bus_address !== exp_addr || reads_done >= FW)
          $display("FAIL read_addr: got %h (read %0d) expected %h (limit %0d)", bus_address, reads_done, exp_addr, FW);
        else passed++;
        q.push_back(bus_readdata);
        last_addr = bus_address;
        exp_addr += 4;
        reads_done++;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; frame_start = 1'b0; pix_req = 1'b0;
    #1;
    total++; if (bus_read !== 1'b0) $display("FAIL rst_read: got %b expected 0", bus_read); else passed++;
    total++; if (bus_address !== BASE) $display("FAIL rst_addr: got %h expected %h", bus_address, BASE); else passed++;
    total++; if (pix_data !== 32'h0) $display("FAIL rst_pix_data: got %h expected 0", pix_data); else passed++;
    total++; if (pix_valid !== 1'b0) $display("FAIL rst_pix_valid: got %b expected 0", pix_valid); else passed++;
    total++; if (underflow !== 1'b0) $display("FAIL rst_underflow: got %b expected 0", underflow); else passed++;
    total++; if (fifo_level !== 5'd0) $display("FAIL rst_level: got %0d expected 0", fifo_level); else passed++;
    total++; if (frame_done !== 1'b0) $display("FAIL rst_frame_done: got %b expected 0", frame_done); else passed++;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_fill();
    enable = 1'b1;
    for (int i = 0; i < 300 && fifo_level != 5'd16; i++) step();
    total++; if (fifo_level !== 5'd16) $display("FAIL fill_level: got %0d expected 16", fifo_level); else passed++;
    repeat (20) step();
    total++; if (bus_read !== 1'b0) $display("FAIL fill_stop: got %b expected 0", bus_read); else passed++;
    total++; if (reads_done != 16) $display("FAIL fill_reads: got %0d expected 16", reads_done); else passed++;
    total++; if (bus_address !== 32'h0000_4040) $display("FAIL fill_addr: got %h expected 00004040", bus_address); else passed++;
  endtask

  task automatic test_pop_one();
    pix_req = 1'b1;
    step();
    pix_req = 1'b0;
    total++; if (pix_valid !== 1'b1) $display("FAIL pop_valid: got %b expected 1", pix_valid); else passed++;
    total++; if (pix_data !== 32'hBFFF_4000) $display("FAIL pop_data: got %h expected bfff4000", pix_data); else passed++;
    total++; if (fifo_level !== 5'd15) $display("FAIL pop_level: got %0d expected 15", fifo_level); else passed++;
    for (int i = 0; i < 10 && !bus_read; i++) step();
    total++; if (bus_read !== 1'b1 || bus_address !== 32'h0000_4040)
      $display("FAIL pop_next_read: got read=%b addr=%h expected read=1 addr=00004040", bus_read, bus_address);
    else passed++;
  endtask

  task automatic test_frame_done();
    for (int i = 0; i < 600 && !(frame_done && fifo_level == 5'd0); i++) begin
      pix_req = fifo_level != 5'd0;
      step();
    end
    pix_req = 1'b0;
    total++; if (frame_done !== 1'b1) $display("FAIL done_flag: got %b expected 1", frame_done); else passed++;
    total++; if (reads_done != FW) $display("FAIL done_reads: got %0d expected %0d", reads_done, FW); else passed++;
    total++; if (last_addr !== 32'h0000_404C) $display("FAIL done_last_addr: got %h expected 0000404c", last_addr); else passed++;
    repeat (20) step();
    total++; if (bus_read !== 1'b0 || reads_done != FW)
      $display("FAIL done_quiet: got read=%b reads=%0d expected read=0 reads=%0d", bus_read, reads_done, FW);
    else passed++;
    total++; if (q.size() != 0) $display("FAIL done_drained: got %0d queued expected 0", q.size()); else passed++;
  endtask

  task automatic test_abort();
    salt++;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    total++; if (frame_done !== 1'b0 || bus_address !== BASE)
      $display("FAIL fs_restart: got done=%b addr=%h expected done=0 addr=%h", frame_done, bus_address, BASE);
    else passed++;
    for (int i = 0; i < 100 && !(fifo_level == 5'd3 && bus_read && !bus_wait); i++) step();
    total++; if (!(fifo_level == 5'd3 && bus_read && !bus_wait))
      $display("FAIL abort_setup: got level=%0d read=%b wait=%b expected level=3 read=1 wait=0", fifo_level, bus_read, bus_wait);
    else passed++;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    total++; if (fifo_level !== 5'd0) $display("FAIL abort_level: got %0d expected 0", fifo_level); else passed++;
    total++; if (bus_read !== 1'b0) $display("FAIL abort_read: got %b expected 0", bus_read); else passed++;
    for (int i = 0; i < 10 && !bus_read; i++) step();
    total++; if (bus_read !== 1'b1 || bus_address !== BASE)
      $display("FAIL abort_next: got read=%b addr=%h expected read=1 addr=%h", bus_read, bus_address, BASE);
    else passed++;
    for (int i = 0; i < 10 && fifo_level == 5'd0; i++) step();
    total++; if (fifo_level !== 5'd1) $display("FAIL abort_discard: got level %0d expected 1", fifo_level); else passed++;
  endtask

  task automatic test_underflow();
    logic [31:0] old;
    enable = 1'b0;
    repeat (8) step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    old = pix_data;
    pix_req = 1'b1;
    step();
    pix_req = 1'b0;
    total++; if (pix_valid !== 1'b0) $display("FAIL uf_valid: got %b expected 0", pix_valid); else passed++;
    total++; if (pix_data !== old) $display("FAIL uf_data: got %h expected %h", pix_data, old); else passed++;
    total++; if (underflow !== 1'b1) $display("FAIL uf_set: got %b expected 1", underflow); else passed++;
    total++; if (fifo_level !== 5'd0) $display("FAIL uf_level: got %0d expected 0", fifo_level); else passed++;
    repeat (5) step();
    total++; if (underflow !== 1'b1) $display("FAIL uf_sticky: got %b expected 1", underflow); else passed++;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    total++; if (underflow !== 1'b0) $display("FAIL uf_clear: got %b expected 0", underflow); else passed++;
  endtask

  task automatic test_wrap();
    int p0;
    enable = 1'b1;
    salt++;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    p0 = pops;
    for (int i = 0; i < 100 && !(fifo_level == 5'd5 && bus_read && !bus_wait); i++) step();
    pix_req = 1'b1;
    step();
    pix_req = 1'b0;
    total++; if (fifo_level !== 5'd5) $display("FAIL pushpop_level: got %0d expected 5", fifo_level); else passed++;
    for (int f = 0; f < 2; f++) begin
      if (f == 1) begin
        salt++;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
      end
      for (int i = 0; i < 600 && !(frame_done && fifo_level == 5'd0); i++) begin
        pix_req = fifo_level != 5'd0;
        step();
      end
      pix_req = 1'b0;
      total++; if (frame_done !== 1'b1) $display("FAIL wrap_frame%0d: got done=%b expected 1", f, frame_done); else passed++;
    end
    step(); step();
    total++; if (pops - p0 != 2 * FW) $display("FAIL wrap_pops: got %0d expected %0d", pops - p0, 2 * FW); else passed++;
    total++; if (q.size() != 0) $display("FAIL wrap_drained: got %0d queued expected 0", q.size()); else passed++;
  endtask

  task automatic test_reset_mid();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int i = 0; i < 10 && !bus_read; i++) step();
    #2;
    reset = 1'b1;
    #1;
    total++; if (bus_read !== 1'b0) $display("FAIL rstmid_read: got %b expected 0", bus_read); else passed++;
    total++; if (bus_address !== BASE || fifo_level !== 5'd0)
      $display("FAIL rstmid_state: got addr=%h level=%0d expected addr=%h level=0", bus_address, fifo_level, BASE);
    else passed++;
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_pop_one();
    test_frame_done();
    test_abort();
    test_underflow();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
